// File: rtl/rr_bus_arbiter.sv
// Round-robin arbiter for one shared datapath resource (bus, ALU input MUX).
// Registered one-hot grant plus encoded select. A grant is held while its owner
// keeps requesting. Every handoff passes through one idle cycle so two drivers
// never overlap. An optional hold limit preempts an owner while others wait.
module rr_bus_arbiter #(
  parameter int unsigned N        = 4,
  parameter int unsigned SW       = (N > 1) ? $clog2(N) : 1,
  parameter int unsigned MAX_HOLD = 8,
  parameter int unsigned CW       = ($clog2(MAX_HOLD + 1) > 0) ? $clog2(MAX_HOLD + 1) : 1
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic [N-1:0]  REQ,
  output logic [N-1:0]  GNT,
  output logic [SW-1:0] SEL,
  output logic          VALID,
  output logic          PREEMPT
);

  localparam logic [0:0]    IDLE     = 1'b0;
  localparam logic [0:0]    OWN      = 1'b1;
  localparam logic [CW-1:0] HOLD_MAX = CW'(MAX_HOLD);
  localparam logic [SW-1:0] LAST_IDX = SW'(N - 1);

  logic [0:0]    state_q, state_d;
  logic [N-1:0]  gnt_q, gnt_d;
  logic [SW-1:0] sel_q, sel_d;
  logic [SW-1:0] ptr_q, ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          preempt_q, preempt_d;

  logic          win_found;
  logic [SW-1:0] win_idx;
  int unsigned   scan_idx;
  logic          others_waiting;
  logic [SW-1:0] ptr_after_owner;

  // Winner search: first set request scanning from the pointer, wrapping mod N.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    scan_idx  = 0;
    for (int unsigned i = 0; i < N; i++) begin
      scan_idx = 32'(ptr_q) + i;
      if (scan_idx >= N) scan_idx = scan_idx - N;
      if (!win_found && REQ[scan_idx[SW-1:0]]) begin
        win_found = 1'b1;
        win_idx   = scan_idx[SW-1:0];
      end
    end
  end

  assign others_waiting  = |(REQ & ~gnt_q);
  assign ptr_after_owner = (sel_q == LAST_IDX) ? '0 : sel_q + SW'(1);

  // Next-state: grant from idle; release, preempt or hold while owned.
  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    sel_d     = sel_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    preempt_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (win_found) begin
          state_d = OWN;
          gnt_d   = N'(1) << win_idx;
          sel_d   = win_idx;
          cnt_d   = CW'(1);
        end
      end
      OWN: begin
        // Release takes priority over preemption, so PREEMPT stays low then.
        if (!REQ[sel_q]) begin
          state_d = IDLE;
          gnt_d   = '0;
          cnt_d   = '0;
          ptr_d   = ptr_after_owner;
        end else if ((MAX_HOLD != 0) && (cnt_q == HOLD_MAX) && others_waiting) begin
          state_d   = IDLE;
          gnt_d     = '0;
          cnt_d     = '0;
          ptr_d     = ptr_after_owner;
          preempt_d = 1'b1;
        end else if ((MAX_HOLD != 0) && (cnt_q != HOLD_MAX)) begin
          cnt_d = cnt_q + CW'(1);
        end
      end
    endcase
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q   <= IDLE;
      gnt_q     <= '0;
      sel_q     <= '0;
      ptr_q     <= '0;
      cnt_q     <= '0;
      preempt_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      sel_q     <= sel_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      preempt_q <= preempt_d;
    end
  end

  // All outputs come straight from registers; no path from REQ.
  assign GNT     = gnt_q;
  assign SEL     = sel_q;
  assign VALID   = |gnt_q;
  assign PREEMPT = preempt_q;

endmodule

// File: tb/tb_rr_bus_arbiter.sv
// Bench for rr_bus_arbiter: directed steps and random requests against an
// integer-level reference model, plus a MAX_HOLD=0 instance.
module tb_rr_bus_arbiter;

  localparam int N  = 4;
  localparam int MH = 4;

  logic       CLK   = 1'b0;
  logic       RST_N = 1'b1;
  logic [3:0] req   = '0;
  logic [3:0] gnt;
  logic [1:0] sel;
  logic       valid, preempt;
  logic [3:0] req0  = '0;
  logic [3:0] gnt0;
  logic [1:0] sel0;
  logic       valid0, preempt0;

  int checks   = 0;
  int failures = 0;

  // Reference model: owner index (-1 = unowned), pointer, tenure length.
  int m_owner = -1;
  int m_sel   = 0;
  int m_ptr   = 0;
  int m_cnt   = 0;
  bit m_pre   = 1'b0;

  always #5 CLK = ~CLK;

  rr_bus_arbiter #(.N(N), .MAX_HOLD(MH)) dut (
    .CLK(CLK), .RST_N(RST_N), .REQ(req), .GNT(gnt), .SEL(sel), .VALID(valid),
    .PREEMPT(preempt)
  );

  rr_bus_arbiter #(.N(N), .MAX_HOLD(0)) dut0 (
    .CLK(CLK), .RST_N(RST_N), .REQ(req0), .GNT(gnt0), .SEL(sel0), .VALID(valid0),
    .PREEMPT(preempt0)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] m_gnt();
    logic [3:0] g;
    g = '0;
    if (m_owner >= 0) g[m_owner[1:0]] = 1'b1;
    return g;
  endfunction

  task automatic model_reset();
    m_owner = -1; m_sel = 0; m_ptr = 0; m_cnt = 0; m_pre = 1'b0;
  endtask

  task automatic model_edge(input logic [3:0] r);
    logic [3:0] own;
    int idx;
    own   = m_gnt();
    m_pre = 1'b0;
    if (m_owner < 0) begin
      for (int i = 0; i < N; i++) begin
        idx = (m_ptr + i) % N;
        if (m_owner < 0 && r[idx[1:0]]) begin
          m_owner = idx; m_sel = idx; m_cnt = 1;
        end
      end
    end else if (!r[m_owner[1:0]]) begin
      m_ptr = (m_owner + 1) % N; m_owner = -1; m_cnt = 0;
    end else if (m_cnt == MH && (r & ~own) != 0) begin
      m_ptr = (m_owner + 1) % N; m_owner = -1; m_cnt = 0; m_pre = 1'b1;
    end else if (m_cnt < MH) begin
      m_cnt++;
    end
  endtask

  // One clock edge: advance the model, then compare just after the edge.
  task automatic step(input string tag);
    @(posedge CLK);
    if (!RST_N) model_reset(); else model_edge(req);
    #1;
    check({tag, ".gnt"},     32'(gnt),     32'(m_gnt()));
    check({tag, ".sel"},     32'(sel),     32'(m_sel));
    check({tag, ".valid"},   32'(valid),   32'(m_owner >= 0));
    check({tag, ".preempt"}, 32'(preempt), 32'(m_pre));
  endtask

  // Assert reset away from any clock edge; outputs must clear immediately.
  task automatic apply_reset();
    RST_N = 1'b0;
    model_reset();
    #1;
    check("rst.gnt",     32'(gnt),     32'(0));
    check("rst.sel",     32'(sel),     32'(0));
    check("rst.valid",   32'(valid),   32'(0));
    check("rst.preempt", 32'(preempt), 32'(0));
    @(negedge CLK);
    RST_N = 1'b1;
  endtask

  // Structural invariants on both instances.
  logic       p_valid  = 1'b0, p_valid0 = 1'b0;
  logic [1:0] p_sel    = '0,   p_sel0   = '0;
  always @(negedge CLK) begin
    if (!RST_N) begin
      p_valid  = 1'b0;
      p_valid0 = 1'b0;
    end else begin
      check("inv.onehot",  32'($onehot0(gnt)),  32'(1));
      check("inv.valid",   32'(valid),          32'(|gnt));
      if (p_valid && valid) check("inv.sel_stable", 32'(sel), 32'(p_sel));
      check("inv0.onehot", 32'($onehot0(gnt0)), 32'(1));
      check("inv0.valid",  32'(valid0),         32'(|gnt0));
      if (p_valid0 && valid0) check("inv0.sel_stable", 32'(sel0), 32'(p_sel0));
      p_valid  = valid;  p_sel  = sel;
      p_valid0 = valid0; p_sel0 = sel0;
    end
  end

  initial begin
    logic [3:0] seen[$];
    logic [3:0] prev_g;
    int         npre;

    #2;
    apply_reset();

    // Single requester, then release; pointer moves to 1.
    req = 4'b0001;
    step("single");
    check("single.gnt_exp", 32'(gnt), 32'h1);
    check("single.sel_exp", 32'(sel), 32'h0);
    req = 4'b0000;
    step("release");
    check("release.gnt_exp", 32'(gnt), 32'h0);
    req = 4'b0011;
    step("ptr1");
    check("ptr1.gnt_exp", 32'(gnt), 32'h2);
    req = 4'b0000;
    step("ptr1_rel");
    step("ptr1_idle");

    // All requesting: rotating grants, 4-cycle tenures, preempt each time.
    apply_reset();
    req    = 4'b1111;
    prev_g = '0;
    npre   = 0;
    for (int i = 0; i < 24; i++) begin
      step("rr");
      if (gnt != 0 && prev_g == 0) seen.push_back(gnt);
      if (preempt) npre++;
      prev_g = gnt;
    end
    check("rr.count", 32'(seen.size()), 32'(5));
    if (seen.size() == 5) begin
      check("rr.g0", 32'(seen[0]), 32'h1);
      check("rr.g1", 32'(seen[1]), 32'h2);
      check("rr.g2", 32'(seen[2]), 32'h4);
      check("rr.g3", 32'(seen[3]), 32'h8);
      check("rr.g4", 32'(seen[4]), 32'h1);
    end
    check("rr.npreempt", 32'(npre), 32'(4));

    // Lone requester never preempted; counter saturates silently.
    apply_reset();
    req  = 4'b0100;
    npre = 0;
    for (int i = 0; i < 20; i++) begin
      step("lone");
      if (preempt) npre++;
    end
    check("lone.gnt_exp",  32'(gnt),  32'h4);
    check("lone.npreempt", 32'(npre), 32'(0));

    // Release and timeout on the same edge: release wins.
    apply_reset();
    req = 4'b0001;
    for (int i = 0; i < 4; i++) step("hold4");
    req = 4'b0100;
    step("relwin");
    check("relwin.gnt_exp",     32'(gnt),     32'h0);
    check("relwin.preempt_exp", 32'(preempt), 32'h0);
    step("relwin_next");
    check("relwin_next.gnt_exp", 32'(gnt), 32'h4);

    // Asynchronous reset mid-tenure; pointer returns to 0.
    apply_reset();
    req = 4'b0010;
    step("mid_a");
    step("mid_b");
    check("mid.gnt_exp", 32'(gnt), 32'h2);
    apply_reset();
    req = 4'b0011;
    step("post_rst");
    check("post_rst.gnt_exp", 32'(gnt), 32'h1);

    // Random requests with occasional resets.
    apply_reset();
    req = '0;
    for (int i = 0; i < 600; i++) begin
      for (int b = 0; b < N; b++) if ($urandom_range(0, 5) == 0) req[b] = ~req[b];
      if ($urandom_range(0, 199) == 0) apply_reset();
      step("rand");
    end

    // Preemption disabled: owner 0 keeps the grant indefinitely.
    req = '0;
    apply_reset();
    req0 = 4'b0011;
    npre = 0;
    for (int i = 0; i < 30; i++) begin
      step("mh0");
      check("mh0.gnt", 32'(gnt0), 32'h1);
      if (preempt0) npre++;
    end
    check("mh0.npreempt", 32'(npre), 32'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
